// File: rtl/yusf_pkg.sv
// Shared opcodes, FSM states and mode-bit positions for the YUSF custom execution unit.
package yusf_pkg;

    localparam logic [6:0] OPC_LIS = 7'b1110010;
    localparam logic [6:0] OPC_LLM = 7'b1110011;
    localparam logic [6:0] OPC_KS  = 7'b1110001;

    localparam int unsigned MODE_SIGNED_BIT = 25;
    localparam int unsigned MODE_DESC_BIT   = 26;
    localparam int unsigned LEN_W           = 5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LIS_RD,
        ST_LIS_WAIT,
        ST_LIS_WR,
        ST_LLM_RD0,
        ST_LLM_RD1,
        ST_LLM_WAIT,
        ST_LLM_WB,
        ST_KS_INIT,
        ST_KS_OUTER,
        ST_KS_CMP,
        ST_KS_SWAP,
        ST_KS_FIN,
        ST_ILL
    } state_t;

endpackage

// File: rtl/yusf_regfile.sv
// Integer register file: two combinational reads plus a debug read, two write ports for swaps.
module yusf_regfile
    import yusf_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned RIDX_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RIDX_W-1:0] ra_idx,
    input  logic [RIDX_W-1:0] rb_idx,
    input  logic [RIDX_W-1:0] dbg_idx,
    output logic [XLEN-1:0]   ra_data,
    output logic [XLEN-1:0]   rb_data,
    output logic [XLEN-1:0]   dbg_data,
    input  logic              we_a,
    input  logic [RIDX_W-1:0] waddr_a,
    input  logic [XLEN-1:0]   wdata_a,
    input  logic              we_b,
    input  logic [RIDX_W-1:0] waddr_b,
    input  logic [XLEN-1:0]   wdata_b
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(NREG); k++) begin
                regs[k] <= '0;
            end
        end else begin
            if (we_a && (waddr_a != '0)) regs[waddr_a] <= wdata_a;
            if (we_b && (waddr_b != '0)) regs[waddr_b] <= wdata_b;
        end
    end

    // x0 is hardwired to zero on every read port
    assign ra_data  = (ra_idx  == '0) ? '0 : regs[ra_idx];
    assign rb_data  = (rb_idx  == '0) ? '0 : regs[rb_idx];
    assign dbg_data = (dbg_idx == '0) ? '0 : regs[dbg_idx];

endmodule

// File: rtl/yusf_custom_exec_unit.sv
// Multi-cycle executor for the load-increment-store, load-load-multiply and in-register sort instructions; owns the register file.
module yusf_custom_exec_unit
    import yusf_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned RIDX_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [31:0]       cmd_instr,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic [XLEN-1:0]   mem_wdata,
    output logic              mem_we,
    output logic              done,
    output logic              err,
    input  logic              rf_we,
    input  logic [RIDX_W-1:0] rf_waddr,
    input  logic [XLEN-1:0]   rf_wdata,
    input  logic [RIDX_W-1:0] dbg_idx,
    output logic [XLEN-1:0]   dbg_data
);

    state_t            state, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   sum_q, sum_d, d0_q, d0_d, d1_q, d1_d;
    logic [LEN_W-1:0]  i_q, i_d, j_q, j_d, m_q, m_d;
    logic              ks_err_q, ks_err_d;

    logic [RIDX_W-1:0] ra_idx, rb_idx, waddr_a, waddr_b;
    logic [XLEN-1:0]   ra_data, rb_data, wdata_a, wdata_b;
    logic              we_a, we_b;

    logic [4:0]        rd_f, rs1_f, len_f;
    logic [11:0]       imm12;
    logic              sgn_mode, desc_mode, better, unused_bits;
    logic [RIDX_W-1:0] idx_i, idx_j, idx_m;

    assign rd_f        = instr_q[11:7];
    assign rs1_f       = instr_q[19:15];
    assign len_f       = instr_q[24:20];
    assign imm12       = instr_q[31:20];
    assign sgn_mode    = instr_q[MODE_SIGNED_BIT];
    assign desc_mode   = instr_q[MODE_DESC_BIT];
    assign unused_bits = ^instr_q[14:12];

    assign idx_i = RIDX_W'({1'b0, rs1_f} + {1'b0, i_q});
    assign idx_j = RIDX_W'({1'b0, rs1_f} + {1'b0, j_q});
    assign idx_m = RIDX_W'({1'b0, rs1_f} + {1'b0, m_q});

    yusf_regfile #(
        .XLEN   (XLEN),
        .NREG   (NREG),
        .RIDX_W (RIDX_W)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .ra_idx   (ra_idx),
        .rb_idx   (rb_idx),
        .dbg_idx  (dbg_idx),
        .ra_data  (ra_data),
        .rb_data  (rb_data),
        .dbg_data (dbg_data),
        .we_a     (we_a),
        .waddr_a  (waddr_a),
        .wdata_a  (wdata_a),
        .we_b     (we_b),
        .waddr_b  (waddr_b),
        .wdata_b  (wdata_b)
    );

    // Strict "better" test: port a holds x[base+j], port b holds the current best x[base+m]
    always_comb begin
        better = 1'b0;
        if (sgn_mode) begin
            better = desc_mode ? ($signed(ra_data) > $signed(rb_data))
                               : ($signed(ra_data) < $signed(rb_data));
        end else begin
            better = desc_mode ? (ra_data > rb_data) : (ra_data < rb_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            instr_q  <= '0;
            addr_q   <= '0;
            sum_q    <= '0;
            d0_q     <= '0;
            d1_q     <= '0;
            i_q      <= '0;
            j_q      <= '0;
            m_q      <= '0;
            ks_err_q <= 1'b0;
        end else begin
            state    <= state_d;
            instr_q  <= instr_d;
            addr_q   <= addr_d;
            sum_q    <= sum_d;
            d0_q     <= d0_d;
            d1_q     <= d1_d;
            i_q      <= i_d;
            j_q      <= j_d;
            m_q      <= m_d;
            ks_err_q <= ks_err_d;
        end
    end

    always_comb begin
        state_d   = state;
        instr_d   = instr_q;
        addr_d    = addr_q;
        sum_d     = sum_q;
        d0_d      = d0_q;
        d1_d      = d1_q;
        i_d       = i_q;
        j_d       = j_q;
        m_d       = m_q;
        ks_err_d  = ks_err_q;
        ra_idx    = '0;
        rb_idx    = '0;
        we_a      = 1'b0;
        waddr_a   = '0;
        wdata_a   = '0;
        we_b      = 1'b0;
        waddr_b   = '0;
        wdata_b   = '0;
        cmd_ready = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        done      = 1'b0;
        err       = 1'b0;

        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                we_a      = rf_we;
                waddr_a   = rf_waddr;
                wdata_a   = rf_wdata;
                if (cmd_valid) begin
                    instr_d  = cmd_instr;
                    ks_err_d = 1'b0;
                    case (cmd_instr[6:0])
                        OPC_LIS: state_d = ST_LIS_RD;
                        OPC_LLM: state_d = ST_LLM_RD0;
                        OPC_KS:  state_d = ST_KS_INIT;
                        default: state_d = ST_ILL;
                    endcase
                end
            end
            ST_LIS_RD: begin
                ra_idx   = RIDX_W'(rs1_f);
                mem_addr = ADDR_W'(ra_data) + ADDR_W'($signed(imm12));
                addr_d   = mem_addr;
                state_d  = ST_LIS_WAIT;
            end
            ST_LIS_WAIT: begin
                mem_addr = addr_q;
                sum_d    = mem_rdata + XLEN'($signed(len_f));
                state_d  = ST_LIS_WR;
            end
            ST_LIS_WR: begin
                mem_addr  = addr_q;
                mem_wdata = sum_q;
                mem_we    = 1'b1;
                done      = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_LLM_RD0: begin
                ra_idx   = RIDX_W'(rs1_f);
                mem_addr = ADDR_W'(ra_data);
                state_d  = ST_LLM_RD1;
            end
            ST_LLM_RD1: begin
                ra_idx   = RIDX_W'(len_f);
                mem_addr = ADDR_W'(ra_data);
                d0_d     = mem_rdata;
                state_d  = ST_LLM_WAIT;
            end
            ST_LLM_WAIT: begin
                d1_d    = mem_rdata;
                state_d = ST_LLM_WB;
            end
            ST_LLM_WB: begin
                we_a    = 1'b1;
                waddr_a = RIDX_W'(rd_f);
                wdata_a = d0_q * d1_q;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            // Range errors take priority over the trivial n<2 case
            ST_KS_INIT: begin
                i_d = '0;
                if ((rs1_f == '0) || ((32'(rs1_f) + 32'(len_f)) > NREG)) begin
                    ks_err_d = 1'b1;
                    state_d  = ST_KS_FIN;
                end else if (len_f < LEN_W'(2)) begin
                    state_d = ST_KS_FIN;
                end else begin
                    state_d = ST_KS_OUTER;
                end
            end
            ST_KS_OUTER: begin
                m_d     = i_q;
                j_d     = i_q + LEN_W'(1);
                state_d = ST_KS_CMP;
            end
            ST_KS_CMP: begin
                ra_idx = idx_j;
                rb_idx = idx_m;
                if (better) m_d = j_q;
                if (j_q == len_f - LEN_W'(1)) begin
                    state_d = ST_KS_SWAP;
                end else begin
                    j_d = j_q + LEN_W'(1);
                end
            end
            ST_KS_SWAP: begin
                ra_idx = idx_i;
                rb_idx = idx_m;
                if (m_q != i_q) begin
                    we_a    = 1'b1;
                    waddr_a = idx_i;
                    wdata_a = rb_data;
                    we_b    = 1'b1;
                    waddr_b = idx_m;
                    wdata_b = ra_data;
                end
                i_d     = i_q + LEN_W'(1);
                state_d = (i_q == len_f - LEN_W'(2)) ? ST_KS_FIN : ST_KS_OUTER;
            end
            ST_KS_FIN: begin
                done    = 1'b1;
                err     = ks_err_q;
                state_d = ST_IDLE;
            end
            ST_ILL: begin
                done    = 1'b1;
                err     = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
